// File: rtl/burst_gen_if.sv
// rtl/burst_gen_if.sv - request/data bundle between sync_bridge and burst_gen
interface burst_gen_if;
    logic       data_req;
    logic       data_valid;
    logic [7:0] dout;
    logic       busy;

    // burst_gen side: takes the request, drives the byte stream
    modport master (
        input  data_req,
        output data_valid,
        output dout,
        output busy
    );

    // consumer side: issues the request, receives the byte stream
    modport slave (
        output data_req,
        input  data_valid,
        input  dout,
        input  busy
    );
endinterface

// File: rtl/burst_gen.sv
// rtl/burst_gen.sv - per-request burst source of LFSR bytes (ramp source when BURST_GEN_RAMP_EN is defined)
module burst_gen #(
    parameter int         BURST_LEN  = 16,
    parameter int         GAP_CYCLES = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic         clk,
    input  logic         resetb,
    burst_gen_if.master  bus
);

    localparam int BW = (BURST_LEN >= 1) ? $clog2(BURST_LEN + 1) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'((BURST_LEN >= 1) ? BURST_LEN - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // an all-zero seed would lock the LFSR, so it is bumped to 1
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("burst_gen: BURST_LEN must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          req_d;
    logic          req_edge;
    logic          pending;
    logic          last_beat;
    logic          last_gap;
    logic          enter_burst;
    logic [BW-1:0] beat_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    lfsr;
    logic [7:0]    lfsr_adv;
    logic          valid_nxt;
    logic [7:0]    dout_nxt;
    logic          busy_nxt;

    // req_d resets high so a request already asserted at reset release is ignored
    assign req_edge    = bus.data_req & ~req_d;
    assign last_beat   = (state == BURST) && (beat_cnt == BEAT_LAST);
    assign last_gap    = (state == GAP) && (gap_cnt == GAP_LAST);
    // a new burst starts from IDLE/GAP, or directly after the last beat when there is no gap
    assign enter_burst = (state_nxt == BURST) && ((state != BURST) || last_beat);

`ifdef BURST_GEN_RAMP_EN
    assign lfsr_adv = lfsr + 8'd1;
`else
    assign lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif

    // state register and request edge history
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            req_d <= 1'b1;
        end else begin
            state <= state_nxt;
            req_d <= bus.data_req;
        end
    end

    // next-state: an edge on the closing cycle counts as a pending request
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_edge) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                    end else if (pending || req_edge) begin
                        state_nxt = BURST;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (last_gap) begin
                    state_nxt = (pending || req_edge) ? BURST : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        valid_nxt = (state_nxt == BURST);
        dout_nxt  = valid_nxt ? lfsr : 8'h00;
        busy_nxt  = (state_nxt != IDLE);
    end

    // beat/gap counters, single-depth pending flag and the data source
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            beat_cnt <= '0;
            gap_cnt  <= '0;
            pending  <= 1'b0;
            lfsr     <= SEED;
        end else begin
            if (enter_burst) begin
                beat_cnt <= '0;
            end else if (state == BURST) begin
                beat_cnt <= beat_cnt + BW'(1);
            end

            if (state != GAP) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + GW'(1);
            end

            if (enter_burst) begin
                pending <= 1'b0;
            end else if (req_edge && (state != IDLE)) begin
                pending <= 1'b1;
            end

            if (valid_nxt) begin
                lfsr <= lfsr_adv;
            end
        end
    end

    // registered outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            bus.data_valid <= 1'b0;
            bus.dout       <= 8'h00;
            bus.busy       <= 1'b0;
        end else begin
            bus.data_valid <= valid_nxt;
            bus.dout       <= dout_nxt;
            bus.busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_burst_gen.sv
// tb/tb_burst_gen.sv - self-checking bench for burst_gen against a burst-schedule model
module tb_burst_gen;

`ifdef BURST_GEN_RAMP_EN
    localparam int         L    = 4;
    localparam int         G    = 0;
    localparam logic [7:0] SEED = 8'hFE;
`else
    localparam int         L    = 16;
    localparam int         G    = 4;
    localparam logic [7:0] SEED = 8'hA5;
`endif
    localparam int NC = 4096;

    logic clk = 1'b0;
    logic resetb;
    burst_gen_if bus_if();

    burst_gen #(.BURST_LEN(L), .GAP_CYCLES(G), .LFSR_SEED(SEED)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: each accepted request books a window of L beats plus G gap cycles
    bit         ev [0:NC-1];
    bit         eb [0:NC-1];
    logic [7:0] ed [0:NC-1];
    int         cyc = 0;
    int         last_start;
    bit         req_prev;
    logic [7:0] mval;

    function automatic logic [7:0] mnext(input logic [7:0] x);
`ifdef BURST_GEN_RAMP_EN
        return x + 8'd1;
`else
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
`endif
    endfunction

    function automatic void model_clear();
        last_start = -1000;
        req_prev   = 1'b1;
        mval       = (SEED == 8'h00) ? 8'h01 : SEED;
        for (int i = 0; i < NC; i++) begin
            if (i >= cyc) begin
                ev[i] = 1'b0;
                eb[i] = 1'b0;
                ed[i] = 8'h00;
            end
        end
    endfunction

    function automatic void schedule(input int e);
        int s;
        if (last_start >= e) return;          // one request already waiting
        s = (e > last_start + L + G) ? e : last_start + L + G;
        for (int i = 0; i < L + G; i++) begin
            if (s + i < NC) begin
                eb[s + i] = 1'b1;
                if (i < L) begin
                    ev[s + i] = 1'b1;
                    ed[s + i] = mval;
                    mval = mnext(mval);
                end
            end
        end
        last_start = s;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (resetb === 1'b1) begin
            if (bus_if.data_req && !req_prev) schedule(cyc);
            req_prev = bus_if.data_req;
        end
    end

    // compare process and run statistics
    bit         chk_en = 1'b0;
    int         n_valid, n_busy, run_v, max_v, run_b, max_b;
    logic [7:0] bq[$];

    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            check("data_valid", bus_if.data_valid, ev[cyc]);
            check("dout", bus_if.dout, ed[cyc]);
            check("busy", bus_if.busy, eb[cyc]);
            if (bus_if.data_valid === 1'b1) begin
                n_valid++;
                run_v++;
                if (run_v > max_v) max_v = run_v;
                bq.push_back(bus_if.dout);
            end else begin
                run_v = 0;
            end
            if (bus_if.busy === 1'b1) begin
                n_busy++;
                run_b++;
                if (run_b > max_b) max_b = run_b;
            end else begin
                run_b = 0;
            end
        end
    end

    function automatic logic [7:0] qget(input int i);
        if (i < bq.size()) return bq[i];
        return 8'hxx;
    endfunction

    task automatic start_test();
        n_valid = 0; n_busy = 0; run_v = 0; max_v = 0; run_b = 0; max_b = 0;
        bq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int n);
        bus_if.data_req = 1'b1;
        repeat (n) @(negedge clk);
        bus_if.data_req = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, bus_if.data_valid, 1'b0);
        check({tag, "_dout"}, bus_if.dout, 8'h00);
        check({tag, "_busy"}, bus_if.busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetb = 1'b0;
        model_clear();
        #1 check_cleared("rst");
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        idle(2);
    endtask

    initial begin
        resetb = 1'b1;
        bus_if.data_req = 1'b0;
        model_clear();
        #3 resetb = 1'b0;
        #1 check_cleared("por");
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        idle(2);

`ifdef BURST_GEN_RAMP_EN
        // back-to-back requests with no gap: continuous ramp across two bursts
        start_test();
        pulse(1); idle(1); pulse(1); idle(20);
        check("t6_beats", n_valid, 8);
        check("t6_run", max_v, 8);
        check("t6_b0", qget(0), 8'hFE);
        check("t6_b1", qget(1), 8'hFF);
        check("t6_b2", qget(2), 8'h00);
        check("t6_b3", qget(3), 8'h01);
        check("t6_b7", qget(7), 8'h05);
`else
        // single long request
        start_test();
        pulse(21); idle(40);
        check("t1_beats", n_valid, 16);
        check("t1_run", max_v, 16);
        check("t1_busy", n_busy, 20);
        check("t1_busy_run", max_b, 20);
        check("t1_b0", qget(0), 8'hA5);
        check("t1_b1", qget(1), 8'h4A);
        check("t1_b2", qget(2), 8'h95);

        // two requests 40 cycles apart: the sequence carries over
        do_reset();
        start_test();
        pulse(21); idle(19); pulse(21); idle(40);
        check("t2_beats", n_valid, 32);
        check("t2_b0", qget(0), 8'hA5);
        check("t2_b16_not_seed", (qget(16) !== 8'hA5), 1'b1);

        // second edge at beat 5: back-to-back burst after the gap
        do_reset();
        start_test();
        pulse(2); idle(3); pulse(2); idle(60);
        check("t3_beats", n_valid, 32);
        check("t3_busy", n_busy, 40);
        check("t3_busy_run", max_b, 40);

        // three edges in one burst: only one extra burst
        do_reset();
        start_test();
        pulse(2); idle(2); pulse(2); idle(2); pulse(2); idle(70);
        check("t4_beats", n_valid, 32);
        check("t4_busy", n_busy, 40);

        // reset at beat 7 with the request held high
        do_reset();
        start_test();
        bus_if.data_req = 1'b1;
        idle(7);
        #1 check("t5_pre_beats", bq.size(), 7);
        #1 resetb = 1'b0;
        model_clear();
        #1 check_cleared("t5_mid");
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        idle(30);
        check("t5_no_burst", n_valid, 7);
        bus_if.data_req = 1'b0;
        idle(3);
        start_test();
        pulse(21); idle(30);
        check("t5_beats", n_valid, 16);
        check("t5_b0", qget(0), 8'hA5);
        check("t5_b1", qget(1), 8'h4A);
`endif
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
